regfile_scoreboard: RTL and testbench

//   Integer register file plus in-flight scoreboard. Sinks the writeback port
//   (rdvalid/rdnum/rddata) and sources operands r0data/r1data to decode/issue.

---
 rtl/regfile_scoreboard.sv | 67 ++++++
 tb/tb_regfile_scoreboard.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: RV32I integer register file with an issue-side RAW/WAW scoreboard
module regfile_scoreboard #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter bit BYPASS = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [4:0]      rs1num_i,
  input  logic [4:0]      rs2num_i,
  input  logic            rs1use_i,
  input  logic            rs2use_i,
  input  logic            rdwr_i,
  input  logic [4:0]      rdnum_i,
  output logic [XLEN-1:0] r0data_o,
  output logic [XLEN-1:0] r1data_o,
  input  logic            rdvalid_i,
  input  logic [4:0]      rdnum_wb_i,
  input  logic [XLEN-1:0] rddata_i,
  input  logic            flush_i,
  output logic [NREG-1:0] busy_o
);
  logic [XLEN-1:0] r_regs [NREG];
  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_wb_mask;
  logic [NREG-1:0] w_fwd_mask;
  logic [NREG-1:0] w_eff_busy;
  logic [NREG-1:0] w_set_mask;
  logic [NREG-1:0] w_busy_nxt;
  logic            w_hazard;
  logic            w_fire;
  // One-hot writeback mask; the forwarded view hides a busy bit being retired this cycle
  always_comb begin
    w_wb_mask  = rdvalid_i ? (NREG'(1) << rdnum_wb_i) : '0;
    w_fwd_mask = BYPASS ? w_wb_mask : '0;
    w_eff_busy = r_busy & ~w_fwd_mask;
  end
  // Hazard check and issue handshake; ready does not look at valid
  always_comb begin
    w_hazard = (rs1use_i && w_eff_busy[rs1num_i]) || (rs2use_i && w_eff_busy[rs2num_i])
               || (rdwr_i && w_eff_busy[rdnum_i]);
    ready_o  = !w_hazard && !flush_i;
    w_fire   = valid_i && ready_o;
  end
  // Operand reads: x0 is zero, same-cycle writeback forwards ahead of the array
  always_comb begin
    r0data_o = (rs1num_i == 5'd0) ? '0 : (w_fwd_mask[rs1num_i] ? rddata_i : r_regs[rs1num_i]);
    r1data_o = (rs2num_i == 5'd0) ? '0 : (w_fwd_mask[rs2num_i] ? rddata_i : r_regs[rs2num_i]);
  end
  // Next scoreboard: flush clears all, otherwise retire then set (set wins); x0 never busy
  always_comb begin
    w_set_mask    = (w_fire && rdwr_i) ? (NREG'(1) << rdnum_i) : '0;
    w_busy_nxt    = flush_i ? '0 : ((r_busy & ~w_wb_mask) | w_set_mask);
    w_busy_nxt[0] = 1'b0;
  end
  // Scoreboard state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_busy <= '0;
    else r_busy <= w_busy_nxt;
  // Register array commit; writes to x0 are discarded
  always_ff @(posedge clk or negedge rst)
    if (!rst) for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    else if (rdvalid_i && rdnum_wb_i != 5'd0) r_regs[rdnum_wb_i] <= rddata_i;
  assign busy_o = r_busy;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed scenarios plus randomized traffic against an array/bitmap model
module tb_regfile_scoreboard;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_i, rs1use_i, rs2use_i, rdwr_i, rdvalid_i, flush_i;
  logic [4:0]  rs1num_i, rs2num_i, rdnum_i, rdnum_wb_i;
  logic [31:0] rddata_i;
  logic        ready_o;
  logic [31:0] r0data_o, r1data_o, busy_o;
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] m_regs [32];
  bit          m_busy [32];
  bit          m_fired;
  regfile_scoreboard dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
    .rs1num_i(rs1num_i), .rs2num_i(rs2num_i), .rs1use_i(rs1use_i), .rs2use_i(rs2use_i),
    .rdwr_i(rdwr_i), .rdnum_i(rdnum_i), .r0data_o(r0data_o), .r1data_o(r1data_o),
    .rdvalid_i(rdvalid_i), .rdnum_wb_i(rdnum_wb_i), .rddata_i(rddata_i),
    .flush_i(flush_i), .busy_o(busy_o)
  );
  always #5 clk = ~clk;
  function automatic bit m_eff_busy(input logic [4:0] r);
    return m_busy[r] && !(rdvalid_i && rdnum_wb_i == r);
  endfunction
  function automatic bit m_ready();
    bit hz;
    hz = (rs1use_i && m_eff_busy(rs1num_i)) || (rs2use_i && m_eff_busy(rs2num_i))
         || (rdwr_i && m_eff_busy(rdnum_i));
    return !hz && !flush_i;
  endfunction
  function automatic logic [31:0] m_read(input logic [4:0] r);
    if (r == 0) return 32'd0;
    if (rdvalid_i && rdnum_wb_i == r) return rddata_i;
    return m_regs[r];
  endfunction
  function automatic logic [31:0] m_busy_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_busy[i];
    return v;
  endfunction
  task automatic m_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 0;
      m_busy[i] = 0;
    end
  endtask
  task automatic idle();
    valid_i = 0; rs1use_i = 0; rs2use_i = 0; rdwr_i = 0; rdvalid_i = 0; flush_i = 0;
    rs1num_i = 0; rs2num_i = 0; rdnum_i = 0; rdnum_wb_i = 0; rddata_i = 0;
  endtask
  // Advance one clock: apply the spec's update rules to the model at the edge, then step off it
  task automatic tick();
    bit fire;
    @(posedge clk);
    fire = valid_i && m_ready();
    m_fired = fire;
    if (rdvalid_i && rdnum_wb_i != 0) m_regs[rdnum_wb_i] = rddata_i;
    if (flush_i) begin
      for (int i = 0; i < 32; i++) m_busy[i] = 0;
    end else begin
      if (rdvalid_i) m_busy[rdnum_wb_i] = 0;
      if (fire && rdwr_i && rdnum_i != 0) m_busy[rdnum_i] = 1;
    end
    #1;
  endtask
  task automatic test_reset();
    idle();
    rs1use_i = 1; rs2use_i = 1; rdwr_i = 1;
    #2;
    vectors++;
    if (busy_o !== 32'd0) begin miscompares++; $display("FAIL reset_busy got %h want 0", busy_o); end
    vectors++;
    if (ready_o !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b want 1", ready_o); end
    for (int i = 0; i < 32; i++) begin
      rs1num_i = 5'(i); rs2num_i = 5'(31 - i);
      #1;
      vectors++;
      if (r0data_o !== 0 || r1data_o !== 0) begin
        miscompares++; $display("FAIL reset_read idx %0d got %h/%h want 0/0", i, r0data_o, r1data_o);
      end
    end
    rst = 1;
    idle();
    tick();
  endtask
  task automatic test_write_read();
    idle();
    rdvalid_i = 1; rdnum_wb_i = 5; rddata_i = 32'hDEADBEEF;
    tick();
    idle();
    rs1num_i = 5;
    #2;
    vectors++;
    if (r0data_o !== 32'hDEADBEEF) begin miscompares++; $display("FAIL write_x5 got %h want deadbeef", r0data_o); end
    rdvalid_i = 1; rdnum_wb_i = 0; rddata_i = 32'h1234;
    tick();
    idle();
    #2;
    vectors++;
    if (r0data_o !== 0 || r1data_o !== 0) begin miscompares++; $display("FAIL write_x0 got %h/%h want 0", r0data_o, r1data_o); end
    vectors++;
    if (busy_o !== 0) begin miscompares++; $display("FAIL write_nobusy got %h want 0", busy_o); end
  endtask
  task automatic test_raw_stall();
    idle();
    valid_i = 1; rdwr_i = 1; rdnum_i = 7;
    #2;
    vectors++;
    if (ready_o !== 1'b1) begin miscompares++; $display("FAIL raw_issue_ready got %b want 1", ready_o); end
    tick();
    idle();
    valid_i = 1; rs2use_i = 1; rs2num_i = 7;
    for (int c = 0; c < 3; c++) begin
      #2;
      vectors++;
      if (ready_o !== 1'b0 || busy_o[7] !== 1'b1) begin
        miscompares++; $display("FAIL raw_stall cyc %0d ready %b busy7 %b want 0/1", c, ready_o, busy_o[7]);
      end
      tick();
    end
    rdvalid_i = 1; rdnum_wb_i = 7; rddata_i = 32'h55;
    #2;
    vectors++;
    if (ready_o !== 1'b1 || r1data_o !== 32'h55) begin
      miscompares++; $display("FAIL raw_bypass ready %b data %h want 1/55", ready_o, r1data_o);
    end
    tick();
    idle();
    #2;
    vectors++;
    if (busy_o !== 0) begin miscompares++; $display("FAIL raw_clear got %h want 0", busy_o); end
  endtask
  task automatic test_same_cycle();
    idle();
    rdvalid_i = 1; rdnum_wb_i = 3; rddata_i = 32'h3333_0003;
    valid_i = 1; rdwr_i = 1; rdnum_i = 3;
    tick();
    idle();
    rs1num_i = 3;
    #2;
    vectors++;
    if (busy_o !== 32'h8) begin miscompares++; $display("FAIL same_busy got %h want 00000008", busy_o); end
    vectors++;
    if (r0data_o !== 32'h3333_0003) begin miscompares++; $display("FAIL same_data got %h want 33330003", r0data_o); end
    rdvalid_i = 1; rdnum_wb_i = 3; rddata_i = 32'h3;
    tick();
    idle();
  endtask
  task automatic test_flush();
    idle();
    valid_i = 1; rdwr_i = 1; rdnum_i = 4;
    tick();
    rdnum_i = 9;
    tick();
    idle();
    #2;
    vectors++;
    if (busy_o !== 32'h210) begin miscompares++; $display("FAIL flush_pre got %h want 00000210", busy_o); end
    flush_i = 1; rdvalid_i = 1; rdnum_wb_i = 4; rddata_i = 32'hA;
    valid_i = 1; rdwr_i = 1; rdnum_i = 12;
    #1;
    vectors++;
    if (ready_o !== 1'b0) begin miscompares++; $display("FAIL flush_ready got %b want 0", ready_o); end
    tick();
    idle();
    rs1num_i = 4;
    #2;
    vectors++;
    if (busy_o !== 0) begin miscompares++; $display("FAIL flush_busy got %h want 0", busy_o); end
    vectors++;
    if (r0data_o !== 32'hA) begin miscompares++; $display("FAIL flush_wb got %h want a", r0data_o); end
  endtask
  task automatic test_reset_mid();
    idle();
    valid_i = 1; rdwr_i = 1; rdnum_i = 8;
    tick();
    idle();
    valid_i = 1; rs1use_i = 1; rs1num_i = 8; rs2num_i = 5;
    #1;
    vectors++;
    if (ready_o !== 1'b0) begin miscompares++; $display("FAIL rstmid_stall got %b want 0", ready_o); end
    rst = 0;
    m_reset();
    #1;
    vectors++;
    if (busy_o !== 0) begin miscompares++; $display("FAIL rstmid_busy got %h want 0", busy_o); end
    vectors++;
    if (r1data_o !== 0) begin miscompares++; $display("FAIL rstmid_regs x5 got %h want 0", r1data_o); end
    #1 rst = 1;
    idle();
    valid_i = 1; rs1use_i = 1; rs1num_i = 8; rdwr_i = 1; rdnum_i = 8;
    #1;
    vectors++;
    if (ready_o !== 1'b1) begin miscompares++; $display("FAIL rstmid_ready got %b want 1", ready_o); end
    tick();
    idle();
    #2;
    vectors++;
    if (busy_o !== 32'h100) begin miscompares++; $display("FAIL rstmid_issue got %h want 00000100", busy_o); end
  endtask
  task automatic test_random();
    bit holding;
    idle();
    holding = 0;
    for (int n = 0; n < 600; n++) begin
      if (!holding) begin
        valid_i  = ($urandom_range(0, 3) != 0);
        rs1use_i = $urandom_range(0, 1); rs2use_i = $urandom_range(0, 1); rdwr_i = $urandom_range(0, 1);
        rs1num_i = 5'($urandom_range(0, 7)); rs2num_i = 5'($urandom_range(0, 7));
        rdnum_i  = 5'($urandom_range(0, 7));
      end
      rdvalid_i  = ($urandom_range(0, 2) == 0);
      rdnum_wb_i = 5'($urandom_range(0, 7));
      rddata_i   = $urandom;
      flush_i    = ($urandom_range(0, 29) == 0);
      #2;
      vectors++;
      if (ready_o !== m_ready()) begin
        miscompares++; $display("FAIL rand_ready n %0d got %b want %b", n, ready_o, m_ready());
      end
      vectors++;
      if (r0data_o !== m_read(rs1num_i) || r1data_o !== m_read(rs2num_i)) begin
        miscompares++;
        $display("FAIL rand_read n %0d got %h/%h want %h/%h", n, r0data_o, r1data_o, m_read(rs1num_i), m_read(rs2num_i));
      end
      vectors++;
      if (busy_o !== m_busy_vec()) begin
        miscompares++; $display("FAIL rand_busy n %0d got %h want %h", n, busy_o, m_busy_vec());
      end
      tick();
      holding = valid_i && !m_fired;
    end
    idle();
  endtask
  initial begin
    idle();
    m_reset();
    #1;
    test_reset();
    test_write_read();
    test_raw_stall();
    test_same_cycle();
    test_flush();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
